if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the ID stage.
- Drives the program counter and the synchronous-read instruction ROM, and absorbs ROM responses during stalls via a one-entry hold buffer.
- Owns the IF/ID pipeline register that feeds decode and the register file.
- Handles stall, redirect (branch/jump flush) and HALT detection.

Parameters:
- PC_W, 16: PC and jump-target width; matches the 16-bit jump location used downstream.
- INSTR_W, 16: instruction word width.
- RESET_PC, 0: first fetch address after reset.
- HALT_OP, 4'hF: opcode (instr[INSTR_W-1 -: 4]) that halts fetch.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr_o  out  PC_W  ROM read address
- imem_rd_o  out  1  ROM read enable; data is valid on imem_data_i in the following cycle
- imem_data_i  in  INSTR_W  ROM read data
- stall_i  in  1  hold the IF/ID register and the PC (from hazard unit)
- redirect_i  in  1  flush and refetch from redirect_pc_i
- redirect_pc_i  in  PC_W  redirect target
- instr_o  out  INSTR_W  IF/ID instruction
- pc_o  out  PC_W  PC of instr_o
- pc_plus1_o  out  PC_W  pc_o+1, modulo 2^PC_W
- valid_o  out  1  instr_o is a real instruction (0 = bubble)
- halted_o  out  1  fetch halted

Behaviour:
- Reset (async, asserted): state=BOOT, fetch_pc=RESET_PC, resp_valid=0, hold_valid=0, valid_o=0, instr_o=0, pc_o=0, halted_o=0, imem_rd_o=0. Reset asserted mid-operation discards everything immediately.
- FSM states:
  - BOOT: imem_rd_o=0 for one cycle, then ->RUN.
  - RUN: fetching.
  - HALTED: no reads.
- RUN with stall_i=0:
  - imem_addr_o=fetch_pc, imem_rd_o=1.
  - On the clock edge: resp_valid<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps to 0).
- IF/ID load, when not stalled: source is the hold buffer if hold_valid, else imem_data_i/resp_pc if resp_valid, else a bubble (valid_o<=0).
- Latency: the first valid instruction appears at IF/ID 3 cycles after rst_n deassertion (BOOT, read, response).
- Stall (stall_i=1):
  - IF/ID, fetch_pc and state hold; imem_rd_o=0.
  - An arriving response (resp_valid) is captured into the hold buffer, setting hold_valid=1.
  - Because reads are suppressed while stalled, at most one response is ever outstanding, so the hold buffer never overflows.
  - First unstalled cycle: IF/ID loads from the hold buffer and a new read issues in the same cycle.
- Redirect (priority over stall and HALTED):
  - Edge at end of cycle R: fetch_pc<=redirect_pc_i; valid_o<=0; resp_valid<=0; hold_valid<=0; state<=RUN.
  - Cycle R+1: the read issues at the target.
  - Cycle R+3: valid_o=1, pc_o=target. valid_o stays 0 in R+1 and R+2.
- HALT:
  - When IF/ID loads an instruction with opcode==HALT_OP, it is passed on with valid_o=1, and state->HALTED with halted_o=1 from the next cycle.
  - Any response in flight behind the HALT is discarded.
  - The next unstalled cycle loads a bubble.
  - Only reset or redirect leaves HALTED.
- Simultaneous events:
  - redirect_i and stall_i together: redirect wins.
  - Redirect arriving while a response is in flight: the response is squashed.

Optional Feature:
- IF_PERF_CNT_EN defined: adds fetch_cnt_o[15:0] and bubble_cnt_o[15:0], both reset to 0 and saturating at 16'hFFFF.
  - fetch_cnt_o counts IF/ID loads with valid=1.
  - bubble_cnt_o counts unstalled cycles that load a bubble.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package cpu_pkg: HALT_OP, NOP_INSTR (all zeros), and enum if_state_t {BOOT, RUN, HALTED}.
- Sub-module if_hold_buf: one-entry skid buffer holding {instr, pc, valid}, with load/drain/clear inputs.

Test Plan:
- Reset then free-run with ROM[i]=16'h1000+i: valid_o rises 3 cycles after rst_n deasserts; pc_o sequences 0,1,2,...; instr_o=16'h1000,16'h1001,...
- Hold stall_i=1 for 3 cycles at pc_o=5: instr_o/pc_o stay at 5 and imem_rd_o=0. Release: pc 6 and 7 then appear on consecutive cycles with no lost or duplicated instruction.
- Pulse redirect_i with target 16'h0040 while a response is in flight: valid_o=0 for 2 cycles, then pc_o=0x40 with ROM[0x40]; the in-flight instruction never appears.
- ROM[3]=16'hF000: instr 3 is delivered with valid_o=1, halted_o=1 the next cycle, no further reads, valid_o=0. A redirect to 0 then restarts fetch and clears halted_o.
- Start at fetch_pc=16'hFFFF via redirect: pc_o goes 0xFFFF, then 0x0000; pc_plus1_o=0x0000 when pc_o=0xFFFF.
- Assert rst_n=0 mid-stall with hold_valid=1: all outputs clear immediately; after release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the IF state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam logic [OPC_W-1:0] HALT_OP = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer that parks a ROM response arriving while IF/ID is stalled.
module if_hold_buf #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  // clear (flush/halt) beats load, load beats drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: drives PC/ROM, owns the IF/ID register, handles stall, redirect and HALT.
// Define IF_PERF_CNT_EN to add saturating fetch_cnt_o / bubble_cnt_o counters.
module if_fetch_stage #(
  parameter int unsigned                  PC_W     = 16,
  parameter int unsigned                  INSTR_W  = 16,
  parameter logic [PC_W-1:0]              RESET_PC = '0,
  parameter logic [cpu_pkg::OPC_W-1:0]    HALT_OP  = cpu_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr_o,
  output logic               imem_rd_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus1_o,
  output logic               valid_o,
  output logic               halted_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt_o,
  output logic [15:0]        bubble_cnt_o
`endif
);

  import cpu_pkg::*;

  if_state_t          state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, resp_pc_q, hold_pc, ld_pc;
  logic [INSTR_W-1:0] hold_instr, ld_instr;
  logic               resp_valid_q, hold_valid, ld_valid;
  logic               rd_c, load_en, halt_hit;

  // Reads only in RUN and never while stalled, so at most one response is in flight
  assign rd_c        = (state_q == RUN) && !stall_i && !redirect_i;
  assign load_en     = !stall_i && !redirect_i;
  assign imem_rd_o   = rd_c;
  assign imem_addr_o = fetch_pc_q;

  if_hold_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (stall_i && resp_valid_q && !redirect_i),
    .drain      (load_en && hold_valid),
    .clear      (redirect_i || halt_hit),
    .load_instr (imem_data_i),
    .load_pc    (resp_pc_q),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  // IF/ID source select, HALT detect and next state
  always_comb begin
    state_d  = state_q;
    ld_valid = 1'b0;
    ld_instr = INSTR_W'(NOP_INSTR);
    ld_pc    = resp_pc_q;
    if (hold_valid) begin
      ld_valid = 1'b1;
      ld_instr = hold_instr;
      ld_pc    = hold_pc;
    end else if (resp_valid_q) begin
      ld_valid = 1'b1;
      ld_instr = imem_data_i;
    end
    halt_hit = load_en && ld_valid && (ld_instr[INSTR_W-1 -: OPC_W] == HALT_OP);
    case (state_q)
      BOOT:    if (!stall_i) state_d = RUN;
      RUN:     if (halt_hit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
    if (redirect_i) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      valid_o      <= 1'b0;
      instr_o      <= '0;
      pc_o         <= '0;
      pc_plus1_o   <= PC_W'(1);
      halted_o     <= 1'b0;
    end else begin
      halted_o <= (state_d == HALTED);
      if (redirect_i) begin
        fetch_pc_q   <= redirect_pc_i;
        resp_valid_q <= 1'b0;
        valid_o      <= 1'b0;
        instr_o      <= INSTR_W'(NOP_INSTR);
      end else begin
        // a HALT reaching IF/ID squashes the read issued behind it
        resp_valid_q <= rd_c && !halt_hit;
        if (rd_c) begin
          fetch_pc_q <= fetch_pc_q + PC_W'(1);
          resp_pc_q  <= fetch_pc_q;
        end
        if (load_en) begin
          valid_o <= ld_valid;
          instr_o <= ld_instr;
          if (ld_valid) begin
            pc_o       <= ld_pc;
            pc_plus1_o <= ld_pc + PC_W'(1);
          end
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (!stall_i) begin
      if (load_en && ld_valid) begin
        if (fetch_cnt_o != 16'hFFFF) fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end else if (bubble_cnt_o != 16'hFFFF) begin
        bubble_cnt_o <= bubble_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order scoreboard of delivered instructions.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr_o;
  logic        imem_rd_o;
  logic [15:0] imem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] instr_o;
  logic [15:0] pc_o;
  logic [15:0] pc_plus1_o;
  logic        valid_o;
  logic        halted_o;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_o;
  logic [15:0] bubble_cnt_o;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic halt_on = 1'b0;
  logic sb_on   = 1'b1;
  logic last_load = 1'b0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr_o   (imem_addr_o),
    .imem_rd_o     (imem_rd_o),
    .imem_data_i   (imem_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus1_o    (pc_plus1_o),
    .valid_o       (valid_o),
    .halted_o      (halted_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (halt_on && a == 16'd3) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  // Synchronous-read ROM
  always @(posedge clk) if (imem_rd_o) imem_data_i <= rom_word(imem_addr_o);

  // Remember whether the last edge was allowed to load IF/ID
  always @(posedge clk) last_load <= rst_n && !stall_i && !redirect_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every freshly loaded valid instruction must match the queue head
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_on && last_load && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(valid_o), 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(pc_o), 32'(e.pc));
        chk("sb_instr", 32'(instr_o), 32'(e.instr));
        chk("sb_pc_plus1", 32'(pc_plus1_o), 32'(16'(e.pc + 16'd1)));
      end
    end
  end

  task automatic wait_pc(input string tag, input logic [15:0] pc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_o && pc_o == pc) && n < 40);
    chk(tag, 32'({valid_o, pc_o}), 32'({1'b1, pc}));
  endtask

  task automatic redirect_pulse(input logic [15:0] target);
    redirect_pc_i = target;
    redirect_i    = 1'b1;
    @(posedge clk);
    #1 redirect_i = 1'b0;
  endtask

  // Called at a negedge with rst_n just released
  task automatic boot_seq();
    #1 chk("boot_rd", 32'(imem_rd_o), 0);
    @(negedge clk);
    chk("boot_valid_c1", 32'(valid_o), 0);
    chk("run_rd", 32'(imem_rd_o), 1);
    chk("run_addr", 32'(imem_addr_o), 0);
    @(negedge clk);
    chk("boot_valid_c2", 32'(valid_o), 0);
    @(negedge clk);
    chk("first_valid", 32'({valid_o, pc_o}), 32'h1_0000);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_instr", 32'(instr_o), 0);
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_rd", 32'(imem_rd_o), 0);

    // Free run from reset
    for (int i = 0; i < 6; i++) push(16'(i), 16'(16'h1000 + i));
    rst_n = 1'b1;
    boot_seq();
    wait_pc("reach_pc5", 16'd5);

    // Three-cycle stall at pc 5
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", 32'(pc_o), 5);
      chk("stall_instr", 32'(instr_o), 32'h1005);
      chk("stall_valid", 32'(valid_o), 1);
      chk("stall_rd", 32'(imem_rd_o), 0);
    end
    push(16'd6, 16'h1006);
    push(16'd7, 16'h1007);
    stall_i = 1'b0;
    @(negedge clk);
    chk("unstall_pc6", 32'({valid_o, pc_o}), 32'h1_0006);
    @(negedge clk);
    chk("unstall_pc7", 32'({valid_o, pc_o}), 32'h1_0007);

    // Redirect with the pc8 response in flight
    push(16'h0040, 16'h1040);
    redirect_pulse(16'h0040);
    @(negedge clk);
    chk("redir_valid_r1", 32'(valid_o), 0);
    chk("redir_rd", 32'(imem_rd_o), 1);
    chk("redir_addr", 32'(imem_addr_o), 32'h40);
    @(negedge clk);
    chk("redir_valid_r2", 32'(valid_o), 0);
    @(negedge clk);
    chk("redir_target", 32'({valid_o, pc_o}), 32'h1_0040);

    // HALT at ROM[3]
    halt_on = 1'b1;
    push(16'd0, 16'h1000);
    push(16'd1, 16'h1001);
    push(16'd2, 16'h1002);
    push(16'd3, 16'hF000);
    redirect_pulse(16'h0000);
    wait_pc("halt_pc3", 16'd3);
    @(negedge clk);
    chk("halted", 32'(halted_o), 1);
    chk("halt_valid", 32'(valid_o), 0);
    chk("halt_rd", 32'(imem_rd_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("halted_rd", 32'(imem_rd_o), 0);
      chk("halted_valid", 32'(valid_o), 0);
    end

    // Redirect out of HALTED
    halt_on = 1'b0;
    push(16'd0, 16'h1000);
    redirect_pulse(16'h0000);
    @(negedge clk);
    chk("unhalt", 32'(halted_o), 0);
    wait_pc("restart_pc0", 16'd0);

    // PC wrap
    push(16'hFFFF, 16'h0FFF);
    push(16'h0000, 16'h1000);
    redirect_pulse(16'hFFFF);
    wait_pc("wrap_ffff", 16'hFFFF);
    chk("wrap_plus1", 32'(pc_plus1_o), 0);
    @(negedge clk);
    chk("wrap_pc0", 32'({valid_o, pc_o}), 32'h1_0000);

    // Reset while stalled with the pc1 response parked in the hold buffer
    stall_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_pc", 32'(pc_o), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_instr", 32'(instr_o), 0);
    chk("mid_rst_pc", 32'(pc_o), 0);
    chk("mid_rst_halted", 32'(halted_o), 0);
    chk("mid_rst_rd", 32'(imem_rd_o), 0);
    stall_i = 1'b0;
    repeat (2) @(negedge clk);
    push(16'd0, 16'h1000);
    push(16'd1, 16'h1001);
    push(16'd2, 16'h1002);
    rst_n = 1'b1;
    boot_seq();
    wait_pc("reboot_pc2", 16'd2);
    @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
